// File: rtl/booth_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_arbiter_pkg
//  Description : Shared types and width helpers for the Booth multiplier
//                round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package booth_mul_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Product width of a radix-8 Booth multiplier with K-bit operands
    function automatic int pw(input int k);
        return 2 * k + 3;
    endfunction

    // Width of a counter that must be able to hold the value TMO
    function automatic int wdw(input int tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_arbiter_rr_picker
//  Description : Combinational round-robin pick: first requester at or above
//                the pointer, otherwise the lowest requester (wrap-around).
//  Revision    : 1.0  initial release
// ============================================================================
module booth_mul_arbiter_rr_picker
    import booth_mul_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_rr_ptr,
    output logic [NREQ-1:0]         o_winner,
    output logic [$clog2(NREQ)-1:0] o_winner_idx,
    output logic                    o_any_req
);

    localparam int IW = $clog2(NREQ);

    logic          w_hi_found;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;

    // Lowest set index at/above the pointer, and lowest set index overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = IW'(i);
                if (IW'(i) >= i_rr_ptr) begin
                    w_hi_idx   = IW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign o_any_req    = |i_req;
    assign o_winner_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_onehot
            assign o_winner[g] = o_any_req && (o_winner_idx == IW'(g));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_arbiter
//  Description : Round-robin scheduler sharing one radix-8 Booth multiplier
//                among NREQ requesters, with a WAIT-state watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int K    = 32,
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*K-1:0]   a_in,
    input  logic [NREQ*K-1:0]   x_in,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic                rsp_err,
    output logic [pw(K)-1:0]    rsp_data,
    output logic [K-1:0]        mul_a,
    output logic [K-1:0]        mul_x,
    output logic                mul_start,
    input  logic                mul_done,
    input  logic [pw(K)-1:0]    mul_result,
    output logic                busy
);

    localparam int IW   = $clog2(NREQ);
    localparam int PWID = pw(K);
    localparam int WDW  = wdw(TMO);

    localparam logic [WDW-1:0] C_TMO_LAST = WDW'(TMO - 1);
    localparam logic [IW-1:0]  C_LAST_REQ = IW'(NREQ - 1);

    state_t            r_state;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_cur;
    logic [WDW-1:0]    r_wd_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_rsp_valid;
    logic              r_rsp_err;
    logic [PWID-1:0]   r_rsp_data;
    logic [K-1:0]      r_mul_a;
    logic [K-1:0]      r_mul_x;
    logic              r_mul_start;
    logic              r_busy;

    logic [NREQ-1:0]   w_winner;
    logic [IW-1:0]     w_winner_idx;
    logic              w_any_req;

    booth_mul_arbiter_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_req        (req),
        .i_rr_ptr     (r_rr_ptr),
        .o_winner     (w_winner),
        .o_winner_idx (w_winner_idx),
        .o_any_req    (w_any_req)
    );

    // Arbiter FSM: grant, launch, wait with watchdog, respond
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cur       <= '0;
            r_wd_cnt    <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_mul_a     <= '0;
            r_mul_x     <= '0;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_mul_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt       <= w_winner;
                        r_mul_a     <= a_in[w_winner_idx*K +: K];
                        r_mul_x     <= x_in[w_winner_idx*K +: K];
                        r_cur       <= w_winner_idx;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_wd_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + WDW'(1);
                    // A completion in the last watchdog cycle still wins
                    if (mul_done) begin
                        r_rsp_data         <= mul_result;
                        r_rsp_err          <= 1'b0;
                        r_rsp_valid[r_cur] <= 1'b1;
                        r_state            <= ST_RESP;
                    end else if (r_wd_cnt == C_TMO_LAST) begin
                        r_rsp_data         <= '0;
                        r_rsp_err          <= 1'b1;
                        r_rsp_valid[r_cur] <= 1'b1;
                        r_state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Served requester drops to lowest priority
                    r_rr_ptr <= (r_cur == C_LAST_REQ) ? '0 : r_cur + IW'(1);
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign mul_a     = r_mul_a;
    assign mul_x     = r_mul_x;
    assign mul_start = r_mul_start;
    assign busy      = r_busy;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    a_rsp_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_valid));
    a_start_launch: assert property (@(posedge clk) disable iff (!rst)
        mul_start |-> (r_state == ST_LAUNCH));
    a_single_outstanding: assert property (@(posedge clk) disable iff (!rst)
        mul_start |=> !mul_start);

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mul_arbiter
//  Description : Self-checking bench for booth_mul_arbiter with a multiplier
//                stub of programmable latency and a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_mul_arbiter;

    localparam int K    = 32;
    localparam int NREQ = 4;
    localparam int TMO  = 64;
    localparam int PW   = 2 * K + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*K-1:0] a_in;
    logic [NREQ*K-1:0] x_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_err;
    logic [PW-1:0]     rsp_data;
    logic [K-1:0]      mul_a;
    logic [K-1:0]      mul_x;
    logic              mul_start;
    logic              mul_done;
    logic [PW-1:0]     mul_result;
    logic              busy;

    booth_mul_arbiter #(.K(K), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .x_in       (x_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .mul_a      (mul_a),
        .mul_x      (mul_x),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- multiplier stub (stub_lat == 0 means never done) -----
    int          stub_lat = 0;
    logic        st_active = 1'b0;
    int          st_cnt = 0;
    logic [K-1:0] st_a = '0;
    logic [K-1:0] st_x = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            st_active <= 1'b1;
            st_cnt    <= 1;
            st_a      <= mul_a;
            st_x      <= mul_x;
        end else if (st_active) begin
            if (mul_done) st_active <= 1'b0;
            else          st_cnt    <= st_cnt + 1;
        end
    end

    assign mul_done   = st_active && (stub_lat != 0) && (st_cnt == stub_lat);
    assign mul_result = $signed({{(PW-K){st_a[K-1]}}, st_a}) * $signed({{(PW-K){st_x[K-1]}}, st_x});

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] onehot;
        logic [PW-1:0]   data;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;

    // Response monitor: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                sb_e = sb.pop_front();
                chk("rsp_idx",  128'(rsp_valid), 128'(sb_e.onehot));
                chk("rsp_data", 128'(rsp_data),  128'(sb_e.data));
                chk("rsp_err",  128'(rsp_err),   128'(sb_e.err));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   128'(gnt),       128'(0));
        chk({tag, "_rsp_v"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_err"},   128'(rsp_err),   128'(0));
        chk({tag, "_data"},  128'(rsp_data),  128'(0));
        chk({tag, "_mula"},  128'(mul_a),     128'(0));
        chk({tag, "_mulx"},  128'(mul_x),     128'(0));
        chk({tag, "_start"}, 128'(mul_start), 128'(0));
        chk({tag, "_busy"},  128'(busy),      128'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Single-requester transaction; ecyc = cycle of rsp_valid, grant cycle = 1
    task automatic do_txn(input int idx, input logic [K-1:0] a, input logic [K-1:0] x,
                          input int lat, input logic [PW-1:0] ed, input logic ee,
                          input int ecyc);
        int  cyc;
        bit  seen;
        @(posedge clk); #1;
        stub_lat = lat;
        a_in[idx*K +: K] = a;
        x_in[idx*K +: K] = x;
        req = NREQ'(1) << idx;
        sb.push_back('{onehot: NREQ'(1) << idx, data: ed, err: ee});
        @(negedge clk);
        chk("gnt_cycle0", 128'(gnt), 128'(0));
        @(negedge clk);
        chk("gnt_cycle1",   128'(gnt),       128'(NREQ'(1) << idx));
        chk("start_cycle1", 128'(mul_start), 128'(1));
        chk("busy_cycle1",  128'(busy),      128'(1));
        chk("mul_a",        128'(mul_a),     128'(a));
        chk("mul_x",        128'(mul_x),     128'(x));
        req = '0;
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== '0) seen = 1;
        end
        chk("rsp_latency", 128'(cyc), 128'(ecyc));
        @(negedge clk);
        chk("busy_after", 128'(busy),      128'(0));
        chk("rsp_pulse",  128'(rsp_valid), 128'(0));
        chk("rsp_hold",   128'(rsp_data),  128'(ed));
    endtask

    logic [K-1:0]  ma    [NREQ];
    logic [K-1:0]  mx    [NREQ];
    logic [PW-1:0] mprod [NREQ];

    // Several requesters held high; ord packs the expected grant order, 2 bits each
    task automatic multi(input logic [NREQ-1:0] mask, input int n, input logic [15:0] ord);
        int cyc;
        int got;
        int w;
        @(posedge clk); #1;
        stub_lat = 3;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*K +: K] = ma[i];
            x_in[i*K +: K] = mx[i];
        end
        for (int k = 0; k < n; k++) begin
            w = int'(ord[2*k +: 2]);
            sb.push_back('{onehot: NREQ'(1) << w, data: mprod[w], err: 1'b0});
        end
        req = mask;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0) begin
                chk("rr_order", 128'(gnt), 128'(NREQ'(1) << ord[2*got +: 2]));
                got++;
                if (got == n) req = '0;
            end
        end
        chk("rr_count", 128'(got), 128'(n));
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("sb_drained", 128'(sb.size()), 128'(0));
        @(negedge clk);
    endtask

    typedef struct {
        int            idx;
        logic [K-1:0]  a;
        logic [K-1:0]  x;
        int            lat;
        logic [PW-1:0] ed;
        logic          ee;
        int            ecyc;
    } vec_t;

    vec_t tv[10];

    initial begin
        int cnt_rsp;
        int cnt_busy;

        tv[0] = '{0, 32'd7,          32'd6,          11, 67'd42,                     1'b0, 13};
        tv[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,   1, 67'd1,                      1'b0,  3};
        tv[2] = '{2, 32'd1000,       32'hFFFF_FFFD,   2, 67'h7_FFFF_FFFF_FFFF_F448,  1'b0,  4};
        tv[3] = '{3, 32'h7FFF_FFFF,  32'h7FFF_FFFF,   5, 67'h0_3FFF_FFFF_0000_0001,  1'b0,  7};
        tv[4] = '{0, 32'h8000_0000,  32'h8000_0000,   7, 67'h0_4000_0000_0000_0000,  1'b0,  9};
        tv[5] = '{1, 32'd12345,      32'd0,           0, 67'd0,                      1'b1, 66};
        tv[6] = '{2, 32'd9,          32'd9,           3, 67'd81,                     1'b0,  5};
        tv[7] = '{3, 32'd5,          32'd11,         64, 67'd55,                     1'b0, 66};
        tv[8] = '{0, 32'd2,          32'd3,          65, 67'd0,                      1'b1, 66};
        tv[9] = '{1, 32'd4,          32'd4,           2, 67'd16,                     1'b0,  4};

        rst  = 1'b0;
        req  = '0;
        a_in = '0;
        x_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_txn(tv[i].idx, tv[i].a, tv[i].x, tv[i].lat, tv[i].ed, tv[i].ee, tv[i].ecyc);
        end

        // All four requesting from rr_ptr = 0: grants 0,1,2,3,0
        do_reset();
        ma[0] = 32'd3;          mx[0] = 32'd5;  mprod[0] = 67'd15;
        ma[1] = 32'hFFFF_FFFF;  mx[1] = 32'd2;  mprod[1] = 67'h7_FFFF_FFFF_FFFF_FFFE;
        ma[2] = 32'd100;        mx[2] = 32'd100; mprod[2] = 67'd10000;
        ma[3] = 32'h8000_0000;  mx[3] = 32'd1;  mprod[3] = 67'h7_FFFF_FFFF_8000_0000;
        multi(4'b1111, 5, 16'h00E4);

        // Serve requester 1, then {0,1} together: 0 must win before 1
        do_txn(1, 32'd6, 32'd7, 4, 67'd42, 1'b0, 6);
        multi(4'b0011, 2, 16'h0004);

        // Reset in the middle of WAIT
        @(posedge clk); #1;
        stub_lat = 20;
        a_in[1*K +: K] = 32'd8;
        x_in[1*K +: K] = 32'd8;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_gnt", 128'(gnt), 128'(4'b0010));
        req = '0;
        repeat (3) @(negedge clk);
        chk("rstw_busy_wait", 128'(busy), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstw");
        cnt_rsp  = 0;
        cnt_busy = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid !== '0) cnt_rsp++;
            if (busy !== 1'b0)    cnt_busy++;
        end
        chk("rstw_no_rsp",  128'(cnt_rsp),  128'(0));
        chk("rstw_no_busy", 128'(cnt_busy), 128'(0));
        do_txn(2, 32'd10, 32'd12, 3, 67'd120, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Round-robin scheduler that shares one radix-8 Booth multiplier top among NREQ requesters.
- Per-requester flow: accepts a request, latches its operands, and pulses the multiplier start. It then waits for the multiplier done and returns the product on a per-requester response strobe.
- Sits between client datapaths and the multiplier top. It is the only source of the multiplier start and operands.
- A watchdog aborts a stalled multiplication and reports an error.

Parameters:
- K, 32, operand width; product width is 2*K+3.
- NREQ, 4, number of requesters (2..8).
- TMO, 64, watchdog limit in cycles spent in WAIT; must exceed multiplier latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  request per requester; held high until gnt.
- a_in  in  NREQ*K  operand a per requester; slice i = bits [i*K +: K].
- x_in  in  NREQ*K  operand x per requester, same slicing.
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands sampled in this cycle.
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe.
- rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort, rsp_data = 0.
- rsp_data  out  2*K+3  product, valid with rsp_valid.
- mul_a  out  K  operand a to multiplier, registered.
- mul_x  out  K  operand x to multiplier, registered.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_done  in  1  multiplier completion, sampled only in WAIT.
- mul_result  in  2*K+3  multiplier product, sampled with mul_done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and rr_ptr to 0.
  - gnt, rsp_valid, rsp_err, rsp_data, mul_a, mul_x, mul_start, busy and wd_cnt all go to 0.
  - Reset mid-operation abandons the transaction; no response is issued.
- IDLE:
  - If req != 0, the winner is the first requester with req set, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - Register gnt[winner]=1, mul_a/mul_x = winner slices, and cur = winner; go to LAUNCH.
  - If req == 0, stay in IDLE.
- LAUNCH:
  - gnt is visible this cycle; mul_start=1 for exactly one cycle.
  - wd_cnt is cleared; go to WAIT.
- WAIT:
  - wd_cnt increments each cycle.
  - If mul_done=1: capture rsp_data=mul_result and rsp_err=0; go to RESP.
  - Else if wd_cnt == TMO-1: rsp_data=0, rsp_err=1; go to RESP.
  - mul_done takes priority if both occur in the same cycle.
- RESP:
  - rsp_valid[cur]=1 for one cycle.
  - rr_ptr = (cur+1) mod NREQ; go to IDLE.
  - rsp_data and rsp_err hold their value until the next RESP.
- mul_a/mul_x are stable from LAUNCH until the next grant.
- mul_done outside WAIT is ignored.
- Latency:
  - req seen in IDLE at cycle 0 → gnt and mul_start at cycle 1.
  - mul_done at cycle n → rsp_valid at cycle n+1.
  - Minimum request-to-request turnaround is 4 cycles plus multiplier latency.
- Fairness: a requester waits at most NREQ-1 other transactions.
- req deasserted before gnt is legal; the request is simply dropped.
- A requester re-asserting req right after its response goes last in priority.
- Simultaneous requests are resolved purely by rr_ptr; there is no fixed priority.
- No back-pressure on responses: the requester must accept rsp_valid.
- Assertions:
  - gnt and rsp_valid are always onehot0.
  - mul_start only in LAUNCH.
  - At most one outstanding multiplication.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3.
  - Product width function PW(K)=2*K+3.
  - Watchdog width function $clog2(TMO+1).
- Sub-module rr_picker (combinational): inputs req and rr_ptr, outputs one-hot winner plus index and any_req. Reused by other shared-unit schedulers in the codebase.
- The FSM, operand registers and watchdog counter stay in booth_mul_arbiter.

Test Plan:
- Single request: req=4'b0001, a=7, x=6, multiplier stub done after 11 cycles → gnt[0] at cycle 1, mul_start at cycle 1, rsp_valid[0] with rsp_data=42, rsp_err=0, busy low afterward.
- All requesting: req=4'b1111 held throughout, rr_ptr=0 → grants in order 0,1,2,3,0; each rsp_valid matches its a*x (e.g. 3*5=15, 0xFFFFFFFF*2 sign-correct per multiplier).
- Rotation skip: after serving requester 1, req=4'b0011 → next grant is requester 0, not 1; then 1 again.
- Watchdog: stub never asserts done, TMO=64 → rsp_valid[cur]=1, rsp_err=1, rsp_data=0 exactly 64 cycles after entering WAIT; the next request proceeds normally.
- Done/timeout tie: mul_done asserted in the cycle wd_cnt==TMO-1 → rsp_err=0, product returned.
- Reset mid-WAIT: rst=0 for 1 cycle during WAIT → all outputs 0, no rsp_valid, a later mul_done is ignored, and a new req=4'b0100 is granted to requester 2 within 1 cycle.
